// File: rtl/mem_wait_ctrl_if.sv
// Z80 bus strobes, address/data and the controller's replies, as seen by mem_wait_ctrl.
interface mem_wait_ctrl_if;
  logic       mreq_n;
  logic       rfsh_n;
  logic       iorq_n;
  logic       rd_n;
  logic       wr_n;
  logic       m1_n;
  logic [7:0] addr_l;
  logic [7:0] d_in;
  logic [7:0] d_out;
  logic       d_oe;
  logic       wait_n;

  // The CPU owns a bus cycle from the strobe falling until it rises again;
  // wait_n low stalls the cycle in Tw, and the cycle completes once wait_n is high.
  modport master (
    output mreq_n,
    output rfsh_n,
    output iorq_n,
    output rd_n,
    output wr_n,
    output m1_n,
    output addr_l,
    output d_in,
    input  d_out,
    input  d_oe,
    input  wait_n
  );

  modport slave (
    input  mreq_n,
    input  rfsh_n,
    input  iorq_n,
    input  rd_n,
    input  wr_n,
    input  m1_n,
    input  addr_l,
    input  d_in,
    output d_out,
    output d_oe,
    output wait_n
  );
endinterface

// File: rtl/mem_wait_ctrl.sv
// Z80 wait-state controller: stretches slow ROM / RAM2 cycles by a programmable T-state count.
// Optional macro WAIT_IO_EN adds a UART wait register at CFG_PORT+1 and I/O-cycle stretching.
module mem_wait_ctrl #(
  parameter logic [7:0] CFG_PORT   = 8'h21,
  parameter logic [3:0] DEF_ROM_WS = 4'd3,
  parameter logic [3:0] DEF_RAM_WS = 4'd2,
  parameter logic [3:0] DEF_IO_WS  = 4'd1
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           cpu_clk,
  input  logic           turbo,
  input  logic           rom_sel,
  input  logic           ram_sel,
  input  logic           uart_sel,
  mem_wait_ctrl_if.slave bus,
  output logic [1:0]     fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic       wait_q;
  logic       wait_nx;
  logic       skip_q;
  logic       skip_nx;
  logic       io_cyc;
  logic       io_cyc_nx;
  logic       cpu_clk_q;
  logic       tick;
  logic       wr_arm;
  logic [3:0] rom_ws;
  logic [3:0] ram_ws;
  logic [3:0] ws_io;
  logic [3:0] load_ws;
  logic       io_wr;
  logic       io_rd;
  logic       cfg_hit;
  logic       cfg_we;
  logic       mem_start;
  logic       io_start;
  logic       cyc_end;
  logic [7:0] rd_data;
  logic       rd_oe;

  // ---------------------------------------------------------------------------
  // I/O register access decode
  // ---------------------------------------------------------------------------
  assign io_wr   = !bus.iorq_n && !bus.wr_n && wr_arm;
  assign io_rd   = !bus.iorq_n && !bus.rd_n && bus.m1_n;
  assign cfg_hit = (bus.addr_l == CFG_PORT);
  assign cfg_we  = io_wr && cfg_hit;

  // Armed by any clk with wr_n high, spent by the first write seen, so one I/O cycle writes once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_arm <= 1'b0;
    end else if (bus.wr_n) begin
      wr_arm <= 1'b1;
    end else if (io_wr) begin
      wr_arm <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rom_ws <= DEF_ROM_WS;
      ram_ws <= DEF_RAM_WS;
    end else if (cfg_we) begin
      rom_ws <= bus.d_in[3:0];
      ram_ws <= bus.d_in[7:4];
    end
  end

`ifdef WAIT_IO_EN
  localparam logic [7:0] IO_PORT = CFG_PORT + 8'd1;

  logic [3:0] io_ws;
  logic       io_hit;
  logic       io_we;

  assign io_hit = (bus.addr_l == IO_PORT);
  assign io_we  = io_wr && io_hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      io_ws <= DEF_IO_WS;
    end else if (io_we) begin
      io_ws <= bus.d_in[3:0];
    end
  end

  // Interrupt acknowledge has m1_n low, so it is excluded here.
  assign io_start = !bus.iorq_n && bus.m1_n && uart_sel;
  assign ws_io    = io_ws;
  assign cyc_end  = io_cyc ? bus.iorq_n : bus.mreq_n;

  always_comb begin
    rd_oe   = 1'b0;
    rd_data = 8'h00;
    if (io_rd && cfg_hit) begin
      rd_oe   = 1'b1;
      rd_data = {ram_ws, rom_ws};
    end else if (io_rd && io_hit) begin
      rd_oe   = 1'b1;
      rd_data = {4'h0, io_ws};
    end
  end
`else
  logic unused_io;

  assign unused_io = ^{uart_sel, DEF_IO_WS};
  assign io_start  = 1'b0;
  assign ws_io     = 4'd0;
  assign cyc_end   = bus.mreq_n;

  always_comb begin
    rd_oe   = 1'b0;
    rd_data = 8'h00;
    if (io_rd && cfg_hit) begin
      rd_oe   = 1'b1;
      rd_data = {ram_ws, rom_ws};
    end
  end
`endif

  assign bus.d_oe  = rd_oe;
  assign bus.d_out = rd_data;

  // ---------------------------------------------------------------------------
  // T-state tick: every clk in turbo, else the clk after a sampled cpu_clk fall
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpu_clk_q <= 1'b0;
    end else begin
      cpu_clk_q <= cpu_clk;
    end
  end

  assign tick = turbo || (cpu_clk_q && !cpu_clk);

  // ---------------------------------------------------------------------------
  // Wait-state FSM
  // ---------------------------------------------------------------------------
  assign mem_start = !bus.mreq_n && bus.rfsh_n && (rom_sel || ram_sel);
  assign load_ws   = mem_start ? (rom_sel ? rom_ws : ram_ws) : ws_io;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      wait_q <= 1'b1;
      skip_q <= 1'b0;
      io_cyc <= 1'b0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      wait_q <= wait_nx;
      skip_q <= skip_nx;
      io_cyc <= io_cyc_nx;
    end
  end

  // The first COUNT clk is the T-state that loaded the count, so it never consumes a tick.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    wait_nx   = wait_q;
    skip_nx   = skip_q;
    io_cyc_nx = io_cyc;
    case (state)
      IDLE: begin
        wait_nx = 1'b1;
        if (mem_start || io_start) begin
          cnt_nx    = load_ws;
          io_cyc_nx = !mem_start;
          skip_nx   = 1'b1;
          if (load_ws == 4'd0) begin
            state_nx = HOLD;
          end else begin
            state_nx = COUNT;
            wait_nx  = 1'b0;
          end
        end
      end
      COUNT: begin
        if (cyc_end) begin
          state_nx = IDLE;
          wait_nx  = 1'b1;
        end else if (skip_q) begin
          skip_nx = 1'b0;
        end else if (tick) begin
          if (cnt <= 4'd1) begin
            cnt_nx   = 4'd0;
            state_nx = HOLD;
            wait_nx  = 1'b1;
          end else begin
            cnt_nx = cnt - 4'd1;
          end
        end
      end
      HOLD: begin
        wait_nx = 1'b1;
        if (cyc_end) begin
          state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
        wait_nx  = 1'b1;
      end
    endcase
  end

  assign bus.wait_n = wait_q;
  assign fsm_state  = state;

endmodule
